// File: rtl/mem_cmd_initiator_if.sv
// Bus bundle for the memory command initiator: request/response handshake
// plus the outbound (command) and inbound (response) FIFO sides.
interface mem_cmd_initiator_if #(
  parameter int FIFO_WIDTH = 8
);
  // request side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [FIFO_WIDTH-1:0] req_addr;
  logic [FIFO_WIDTH-1:0] req_wdata;
  // outbound command FIFO
  logic                  tx_fifo_full;
  logic                  tx_fifo_wr_en;
  logic [FIFO_WIDTH-1:0] dout;
  // inbound response FIFO
  logic                  rx_fifo_empty;
  logic                  rx_fifo_rd_en;
  logic [FIFO_WIDTH-1:0] din;
  // response / status
  logic                  rsp_valid;
  logic [FIFO_WIDTH-1:0] rsp_data;
  logic [7:0]            done_count;

  // The initiator itself
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  tx_fifo_full, rx_fifo_empty, din,
    output req_ready, tx_fifo_wr_en, dout, rx_fifo_rd_en,
    output rsp_valid, rsp_data, done_count
  );

  // The surroundings: requester plus the two FIFOs
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output tx_fifo_full, rx_fifo_empty, din,
    input  req_ready, tx_fifo_wr_en, dout, rx_fifo_rd_en,
    input  rsp_valid, rsp_data, done_count
  );
endinterface

// File: rtl/mem_cmd_initiator.sv
// Memory command initiator: serialises one request at a time into a
// command/address/data byte stream for the outbound FIFO and, for reads,
// collects the single response byte from the inbound FIFO.
module mem_cmd_initiator #(
  parameter int                    FIFO_WIDTH = 8,
  parameter logic [FIFO_WIDTH-1:0] WR_CMD     = 8'd49,
  parameter logic [FIFO_WIDTH-1:0] RD_CMD     = 8'd48
) (
  input logic               clk,
  input logic               rst,
  mem_cmd_initiator_if.master bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_CMD  = 3'd1;
  localparam logic [2:0] SEND_ADDR = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
  localparam logic [2:0] WAIT_RSP  = 3'd4;
  localparam logic [2:0] LATCH_RSP = 3'd5;

  logic [2:0]            state;
  logic [2:0]            state_next;
  logic                  lat_write;
  logic [FIFO_WIDTH-1:0] lat_addr;
  logic [FIFO_WIDTH-1:0] lat_wdata;
  logic                  rsp_valid;
  logic [FIFO_WIDTH-1:0] rsp_data;
  logic [7:0]            done_count;

  logic                  tx_wr;
  logic [FIFO_WIDTH-1:0] tx_byte;
  logic                  rx_rd;
  logic                  accept;
  logic                  complete;

  // Requests are only taken in IDLE, so a read holds off the next request
  // until its response byte has been latched.
  assign accept = (state == IDLE) && bus.req_valid;

  // A transaction completes on the data-byte write of a write, or on the
  // response-latch cycle of a read.
  assign complete = ((state == SEND_DATA) && !bus.tx_fifo_full) ||
                    (state == LATCH_RSP);

  // Next state and FIFO-side outputs; a full FIFO freezes the current byte.
  always_comb begin
    state_next = state;
    tx_wr      = 1'b0;
    tx_byte    = '0;
    rx_rd      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_next = SEND_CMD;
      end
      SEND_CMD: begin
        tx_wr   = !bus.tx_fifo_full;
        tx_byte = lat_write ? WR_CMD : RD_CMD;
        if (!bus.tx_fifo_full) state_next = SEND_ADDR;
      end
      SEND_ADDR: begin
        tx_wr   = !bus.tx_fifo_full;
        tx_byte = lat_addr;
        if (!bus.tx_fifo_full) state_next = lat_write ? SEND_DATA : WAIT_RSP;
      end
      SEND_DATA: begin
        tx_wr   = !bus.tx_fifo_full;
        tx_byte = lat_wdata;
        if (!bus.tx_fifo_full) state_next = IDLE;
      end
      WAIT_RSP: begin
        // Inbound bytes are only consumed here; anything arriving earlier
        // stays in the FIFO until this read wants it.
        rx_rd = !bus.rx_fifo_empty;
        if (!bus.rx_fifo_empty) state_next = LATCH_RSP;
      end
      LATCH_RSP: begin
        // din is valid now, one cycle after the read enable
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture the request fields on acceptance so the bus may change after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= bus.req_write;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end
  end

  // Response register: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state == LATCH_RSP);
      if (state == LATCH_RSP) rsp_data <= bus.din;
    end
  end

  // Completed-transaction counter, wrapping naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           done_count <= 8'd0;
    else if (complete) done_count <= done_count + 8'd1;
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.tx_fifo_wr_en = tx_wr;
  assign bus.dout          = tx_byte;
  assign bus.rx_fifo_rd_en = rx_rd;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_data      = rsp_data;
  assign bus.done_count    = done_count;

endmodule

// File: tb/tb_mem_cmd_initiator.sv
// Randomised scoreboard bench for mem_cmd_initiator. A memory model and
// modelled FIFOs generate expectations; a negedge monitor checks them.
module tb_mem_cmd_initiator;

  localparam logic [7:0] WR_CMD = 8'd49;
  localparam logic [7:0] RD_CMD = 8'd48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_cmd_initiator_if #(.FIFO_WIDTH(8)) bus ();

  mem_cmd_initiator #(.FIFO_WIDTH(8), .WR_CMD(WR_CMD), .RD_CMD(RD_CMD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] val;
    int         due;
  } pend_t;

  int          total  = 0;
  int          passed = 0;
  int          cyc    = 0;
  int          tx_count = 0;
  int          full_pct = 0;
  bit          force_full = 0;
  bit          rd_taken = 0;
  logic [7:0]  exp_done = 8'd0;
  logic [7:0]  mem [256];
  logic [7:0]  txq [$];
  logic [7:0]  rsp_exp [$];
  logic [7:0]  rxq [$];
  pend_t       pend [$];
  int          txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic flag_fail(input string name);
    total++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // outbound FIFO full flag: random or forced, changed just after each edge
  initial begin
    bus.tx_fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_fifo_full = force_full || (full_pct != 0 && $urandom_range(99) < full_pct);
    end
  end

  // inbound FIFO model: pops on a sampled read enable, data shows next cycle
  initial begin
    bit take;
    bus.din = 8'd0;
    bus.rx_fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      take = bus.rx_fifo_rd_en;
      #1;
      if (rst) begin
        rxq.delete();
        pend.delete();
      end else begin
        if (take && rxq.size() > 0) bus.din = rxq.pop_front();
        while (pend.size() > 0 && pend[0].due <= cyc) rxq.push_back(pend.pop_front().val);
      end
      bus.rx_fifo_empty = (rxq.size() == 0);
    end
  end

  // monitor: compares everything the DUT presents against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rsp_valid) begin
          if (rsp_exp.size() == 0) flag_fail("unexpected_rsp");
          else check("rsp_data", bus.rsp_data, rsp_exp.pop_front());
          rd_taken = 0;
        end
        if (bus.tx_fifo_wr_en) begin
          if (bus.tx_fifo_full) flag_fail("wr_en_while_full");
          if (txq.size() == 0) flag_fail("unexpected_tx_byte");
          else check("tx_byte", bus.dout, txq.pop_front());
          tx_count++;
        end
        if (bus.rx_fifo_rd_en) begin
          if (bus.rx_fifo_empty || rd_taken || txq.size() != 0 || rsp_exp.size() == 0)
            flag_fail("illegal_rd_en");
          rd_taken = 1;
        end
        if (bus.req_ready && (txq.size() != 0 || rsp_exp.size() != 0))
          flag_fail("ready_while_busy");
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
    if (!ok) flag_fail("ready_timeout");
  endtask

  task automatic do_req(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input int delay);
    bit ok;
    pend_t p;
    wait_ready(ok);
    if (!ok) return;
    check("done_count", bus.done_count, exp_done);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bus.req_addr  = $urandom;
    txq.push_back(wr ? WR_CMD : RD_CMD);
    txq.push_back(addr);
    if (wr) begin
      txq.push_back(data);
      mem[addr] = data;
      $display("txn %0d: write addr=%0d data=%0d", txn, addr, data);
    end else begin
      rsp_exp.push_back(mem[addr]);
      p.val = mem[addr];
      p.due = cyc + delay;
      pend.push_back(p);
      $display("txn %0d: read addr=%0d expect=%0d delay=%0d", txn, addr, mem[addr], delay);
    end
    exp_done = exp_done + 8'd1;
    txn++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_wr_en"}, bus.tx_fifo_wr_en, 0);
    check({tag, "_rd_en"}, bus.rx_fifo_rd_en, 0);
    check({tag, "_dout"}, bus.dout, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_done_count"}, bus.done_count, 0);
  endtask

  initial begin
    bit ok;
    int n;
    int start;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'd0;
    bus.req_wdata = 8'd0;
    #2;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // basic write then read of the same location, no backpressure
    do_req(1'b1, 8'd10, 8'd65, 0);
    do_req(1'b0, 8'd10, 8'd0, 0);

    // full asserted right after the command byte for five cycles
    start = tx_count;
    do_req(1'b1, 8'd20, 8'd77, 0);
    n = 0;
    while (tx_count == start && n < 50) begin @(negedge clk); n++; end
    force_full = 1'b1;
    repeat (6) @(posedge clk);
    force_full = 1'b0;

    // long wait for the response byte
    do_req(1'b0, 8'd20, 8'd0, 22);

    // randomised mix with backpressure and response latency
    full_pct = 30;
    for (int i = 0; i < 60; i++)
      do_req(1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom), $urandom_range(6));
    full_pct = 0;

    // asynchronous reset in the middle of a write packet
    wait_ready(ok);
    start = tx_count;
    do_req(1'b1, 8'd10, 8'd99, 0);
    n = 0;
    while (tx_count == start && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #3;
    check("pre_reset_dout", bus.dout, 10);
    rst = 1'b1;
    #1;
    txq.delete();
    rsp_exp.delete();
    rd_taken = 0;
    exp_done = 8'd0;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 256 back-to-back writes wrap the completion counter back to zero
    for (int i = 0; i < 256; i++) do_req(1'b1, 8'(i), 8'(i * 3), 0);
    wait_ready(ok);
    check("done_wrap", bus.done_count, 0);

    // drain the scoreboard
    n = 0;
    while ((txq.size() != 0 || rsp_exp.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("scoreboard_drained", txq.size() + rsp_exp.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_cmd_initiator.md
MEM_CMD_INITIATOR -- requirements
Module: mem_cmd_initiator

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8, giving the byte width of all FIFO-side data.
REQ-002 The block SHALL have parameter WR_CMD, default 8'd49, the write-command byte.
REQ-003 The block SHALL have parameter RD_CMD, default 8'd48, the read-command byte.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, the reset; one clock, reset asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1, meaning a transaction request is present.
REQ-007 The block SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-008 The block SHALL have port req_write, input, 1, selecting a write (1) or a read (0).
REQ-009 The block SHALL have port req_addr, input, FIFO_WIDTH, the memory address.
REQ-010 The block SHALL have port req_wdata, input, FIFO_WIDTH, the write data, ignored for reads.
REQ-011 The block SHALL have port tx_fifo_full, input, 1, the full flag of the outbound (command) FIFO.
REQ-012 The block SHALL have port tx_fifo_wr_en, output, 1, the outbound FIFO write enable.
REQ-013 The block SHALL have port dout, output, FIFO_WIDTH, the outbound byte.
REQ-014 The block SHALL have port rx_fifo_empty, input, 1, the empty flag of the inbound (response) FIFO.
REQ-015 The block SHALL have port rx_fifo_rd_en, output, 1, the inbound FIFO read enable.
REQ-016 The block SHALL have port din, input, FIFO_WIDTH, the inbound FIFO data, valid the cycle after rd_en.
REQ-017 The block SHALL have port rsp_valid, output, 1, a one-cycle pulse carrying read data.
REQ-018 The block SHALL have port rsp_data, output, FIFO_WIDTH, the read data, held until the next response.
REQ-019 The block SHALL have port done_count, output, 8, the number of completed transactions.

Function
REQ-020 The state machine SHALL have states IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, WAIT_RSP and LATCH_RSP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge, which latches req_write, req_addr and req_wdata and moves the machine to SEND_CMD.
REQ-022 In each SEND_* state, tx_fifo_wr_en SHALL equal ~tx_fifo_full (combinational); while tx_fifo_full is 1 the state and dout SHALL hold, with no byte dropped or duplicated.
REQ-023 In SEND_CMD, dout SHALL be WR_CMD if the latched request is a write, else RD_CMD, and the machine SHALL advance to SEND_ADDR on write.
REQ-024 In SEND_ADDR, dout SHALL be the latched address; the machine SHALL advance to SEND_DATA for a write or WAIT_RSP for a read on write.
REQ-025 In SEND_DATA, dout SHALL be the latched write data; on write the machine SHALL return to IDLE and increment done_count.
REQ-026 In WAIT_RSP, rx_fifo_rd_en SHALL equal ~rx_fifo_empty, and the machine SHALL move to LATCH_RSP when it is 1.
REQ-027 In LATCH_RSP, the block SHALL register din into rsp_data, pulse rsp_valid for exactly one cycle, increment done_count and return to IDLE.
REQ-028 Outside WAIT_RSP, rx_fifo_rd_en SHALL be 0; stray inbound bytes SHALL be left in the FIFO.
REQ-029 Outside the SEND_* states, tx_fifo_wr_en SHALL be 0 and dout SHALL be 0.
REQ-030 With no backpressure, for a request accepted on edge 0, the write bytes SHALL be written on edges 1, 2 and 3, and req_ready SHALL return to 1 after edge 3.
REQ-031 With no backpressure, for a read accepted on edge 0, the command and address SHALL be written on edges 1 and 2, and rx_fifo_rd_en SHALL be asserted at the earliest in the cycle before edge 3.
REQ-032 done_count SHALL be 8-bit unsigned and wrap from 255 to 0.
REQ-033 The block SHALL accept only one transaction at a time; a new request SHALL not be taken until the current read's response has been latched.

Reset
REQ-034 While rst is 1, the state SHALL be IDLE, req_ready 1, tx_fifo_wr_en 0, rx_fifo_rd_en 0, dout 0, rsp_valid 0, rsp_data 0 and done_count 0, independent of clk.
REQ-035 Reset asserted mid-packet SHALL abandon the packet immediately; the block relies on the attached FIFOs and controller being reset together.

Verification
REQ-036 Write addr 8'd10, data 8'd65, no backpressure -> outbound bytes 49, 10, 65 on three consecutive edges, and done_count = 1.
REQ-037 Read addr 8'd10, with the responder returning 8'd65 -> outbound bytes 48, 10, then a one-cycle rsp_valid with rsp_data = 65.
REQ-038 tx_fifo_full held at 1 for 5 cycles after the command byte -> the address byte is written once after full drops, with no duplicates.
REQ-039 rx_fifo_empty held at 1 for 20 cycles in WAIT_RSP -> rx_fifo_rd_en stays 0, req_ready stays 0, then completion with the correct data.
REQ-040 256 back-to-back writes -> done_count wraps to 0; rst asserted during SEND_ADDR -> all outputs reach their reset values without a clock edge.
